// File: rtl/core_defs_pkg.sv
// -----------------------------------------------------------------------------
// core_defs_pkg
// Shared core-wide definitions: instruction/address widths, the canonical NOP
// encoding, the default reset PC, and the debug snapshot exported by the fetch
// unit.
// -----------------------------------------------------------------------------
package core_defs_pkg;

  localparam int          ADDR_W       = 32;
  localparam int          INST_W       = 32;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Internal fetch state made visible for checkers and debug.
  // Counters are zero-extended to 8 bits, so DEPTH must stay below 256.
  typedef struct packed {
    logic [7:0] outstanding;  // granted requests whose response is pending
    logic [7:0] discard;      // pending responses that will be dropped
    logic       fifo_full;    // prefetch FIFO holds DEPTH entries
    logic       run;          // issue enabled (low in the first cycle after reset)
  } fetch_dbg_t;

endpackage

// File: rtl/gen_sync_fifo.sv
// -----------------------------------------------------------------------------
// gen_sync_fifo
// Generic single-clock FIFO with a registered storage array. The head entry is
// read straight out of storage, so there is no combinational path from wdata to
// rdata.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, wdata      write request and data; accepted when not full, or when a
//                    pop happens in the same cycle
//   pop              remove head; ignored when empty
//   flush            empty the FIFO; overrides push and pop that cycle
//   rdata            head entry (undefined when empty)
//   full, empty      occupancy flags
//   count            number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module gen_sync_fifo #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty && !flush;
  assign w_do_push = push && (!full || w_do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage feeding the IF/ID register. Owns the PC, issues
// in-order fetches, buffers returned instructions with their addresses in a
// prefetch FIFO, and handles redirects by flushing the FIFO and dropping
// responses that were already in flight.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   jump_en, jump_addr         redirect from execute (highest priority)
//   hold_en                    downstream stall: head is not consumed
//   ibus_req_o, ibus_addr_o    fetch request at the current PC
//   ibus_gnt_i                 request accepted this cycle
//   ibus_rvalid_i, ibus_rdata_i in-order response, >= 1 cycle after grant
//   inst_valid_o, inst_o,      FIFO head; NOP / RESET_PC when empty
//   inst_addr_o
//   dbg_o                      snapshot of counters and FIFO state
//
// Handshakes: a request transfers on a cycle where ibus_req_o && ibus_gnt_i;
// ibus_req_o never depends on ibus_gnt_i. A response transfers on every cycle
// ibus_rvalid_i is high (no back-pressure). The head is consumed on every cycle
// inst_valid_o && !hold_en && !jump_en.
// -----------------------------------------------------------------------------
module if_fetch_unit
  import core_defs_pkg::*;
#(
  parameter int          AW       = ADDR_W,
  parameter int          DW       = INST_W,
  parameter int          DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
  parameter logic [DW-1:0] NOP      = DW'(NOP_INST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  input  logic          hold_en,
  output logic          ibus_req_o,
  output logic [AW-1:0] ibus_addr_o,
  input  logic          ibus_gnt_i,
  input  logic          ibus_rvalid_i,
  input  logic [DW-1:0] ibus_rdata_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output fetch_dbg_t    dbg_o
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [AW-1:0] r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic          r_run;

  logic [CW:0]        w_credit_sum;
  logic               w_grant;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  logic [AW-1:0]      w_rsp_addr;
  logic [AW+DW-1:0]   w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CW-1:0]      w_fifo_count;

  // Credit covers both in-flight requests and buffered entries, so a response
  // always has a FIFO slot. A pop in this cycle deliberately gives no credit,
  // keeping the request free of any path from hold_en.
  assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign ibus_req_o   = r_run && !jump_en && (w_credit_sum < DEPTH_C);
  assign ibus_addr_o  = r_pc;
  assign w_grant      = ibus_req_o && ibus_gnt_i;

  assign w_drop = ibus_rvalid_i && (r_discard != '0);
  assign w_push = ibus_rvalid_i && !w_drop && !jump_en;
  assign w_pop  = !w_fifo_empty && !hold_en && !jump_en;

  // Responses return in order and every one still counted in outstanding was
  // issued from consecutive PCs, so the oldest one belongs to
  // pc - 4*outstanding. Only used when discard is zero; then all outstanding
  // requests belong to the current stream.
  assign w_rsp_addr = r_pc - ({{(AW - CW){1'b0}}, r_outstanding} << 2);

  gen_sync_fifo #(
    .DW    (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (jump_en),
    .wdata ({w_rsp_addr, ibus_rdata_i}),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_run         <= 1'b0;
    end else begin
      r_run <= 1'b1;

      if (jump_en) begin
        r_pc <= jump_addr;
      end else if (w_grant) begin
        r_pc <= r_pc + AW'(4);
      end

      // No request in a jump cycle, so this also covers the jump case.
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(ibus_rvalid_i);

      // Reloaded from the live count on every jump, so back-to-back jumps
      // leave exactly the still-pending responses marked for dropping.
      if (jump_en) begin
        r_discard <= r_outstanding - CW'(ibus_rvalid_i);
      end else if (w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
    end
  end

  assign inst_valid_o = !w_fifo_empty;
  assign inst_o       = w_fifo_empty ? NOP      : w_fifo_rdata[DW-1:0];
  assign inst_addr_o  = w_fifo_empty ? RESET_PC : w_fifo_rdata[AW+DW-1:DW];

  assign dbg_o.outstanding = 8'(r_outstanding);
  assign dbg_o.discard     = 8'(r_discard);
  assign dbg_o.fifo_full   = w_fifo_full;
  assign dbg_o.run         = r_run;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Bench for if_fetch_unit. A bus model grants requests, returns
// mem[addr] = addr ^ 32'hFFFF in order after a programmable latency, and pushes
// the expected {addr, inst} of every grant (from its own PC model) onto exp_q.
// A monitor compares the FIFO head with exp_q whenever inst_valid_o is high.
// Directed checks cover reset values, first-fetch timing and jump timing.
// Inputs change at posedge+1/+2; outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;
  import core_defs_pkg::*;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_V  = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic          hold_en;
  logic          ibus_req_o;
  logic [AW-1:0] ibus_addr_o;
  logic          ibus_gnt_i;
  logic          ibus_rvalid_i;
  logic [DW-1:0] ibus_rdata_i;
  logic          inst_valid_o;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] inst_addr_o;
  fetch_dbg_t    dbg_o;

  int errors = 0;
  int checks = 0;

  logic [AW+DW-1:0] exp_q[$];   // {addr, inst} in delivery order
  logic [AW-1:0]    pend_q[$];  // bus model: granted addresses awaiting response
  int               ready_q[$]; // bus model: cycle each response is due

  int          cyc = 0;
  int          last_ready = 0;
  int          bus_out = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          gnt_rand = 1'b0;
  logic [31:0] ref_pc = RST_PC;

  if_fetch_unit #(
    .AW       (AW),
    .DW       (DW),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC),
    .NOP      (NOP_V)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .hold_en       (hold_en),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .dbg_o         (dbg_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},       64'(ibus_req_o),        64'(0));
    check({tag, "_addr"},      64'(ibus_addr_o),       64'(RST_PC));
    check({tag, "_valid"},     64'(inst_valid_o),      64'(0));
    check({tag, "_inst"},      64'(inst_o),            64'(NOP_V));
    check({tag, "_inst_addr"}, 64'(inst_addr_o),       64'(RST_PC));
    check({tag, "_out"},       64'(dbg_o.outstanding), 64'(0));
    check({tag, "_discard"},   64'(dbg_o.discard),     64'(0));
  endtask

  // ---------------- bus model / expected-value producer ----------------
  initial begin
    int lat;
    int r;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = '0;
      end else begin
        ibus_gnt_i = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (ready_q.size() > 0 && ready_q[0] <= cyc) begin
          ibus_rvalid_i = 1'b1;
          ibus_rdata_i  = pend_q[0] ^ 32'h0000_FFFF;
          void'(pend_q.pop_front());
          void'(ready_q.pop_front());
        end else begin
          ibus_rvalid_i = 1'b0;
          ibus_rdata_i  = 32'hDEAD_BEEF;
        end
      end

      @(negedge clk);
      if (!rst) begin
        pend_q.delete();
        ready_q.delete();
        ref_pc     = RST_PC;
        bus_out    = 0;
        last_ready = 0;
      end else begin
        if (ibus_rvalid_i) bus_out--;
        if (jump_en) begin
          check("req_in_jump_cycle", 64'(ibus_req_o), 64'(0));
          ref_pc = jump_addr;
        end
        if (ibus_req_o && ibus_gnt_i) begin
          check("issue_addr", 64'(ibus_addr_o), 64'(ref_pc));
          exp_q.push_back({ref_pc, ref_pc ^ 32'h0000_FFFF});
          lat = $urandom_range(lat_min, lat_max);
          r = cyc + lat;
          if (r <= last_ready) r = last_ready + 1;
          last_ready = r;
          pend_q.push_back(ibus_addr_o);
          ready_q.push_back(r);
          ref_pc = ref_pc + 32'd4;
          bus_out++;
          checks++;
          if (bus_out > DEPTH) begin
            errors++;
            $display("FAIL outstanding_le_depth: got %0d, expected <= %0d", bus_out, DEPTH);
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst || jump_en) begin
        exp_q.delete();
      end else if (inst_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_inst: got addr %0h inst %0h, expected no valid instruction",
                   inst_addr_o, inst_o);
        end else begin
          e = exp_q[0];
          check("head_addr", 64'(inst_addr_o), 64'(e[AW+DW-1:DW]));
          check("head_inst", 64'(inst_o),      64'(e[DW-1:0]));
          if (!hold_en) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    bit found;
    rst       = 1'b0;
    jump_en   = 1'b0;
    jump_addr = '0;
    hold_en   = 1'b0;

    // Reset state.
    repeat (3) step();
    check_reset_outputs("rst");

    // Sequential fetch after reset release, gnt always high, latency 1.
    rst = 1'b1;                      // cycle 0
    @(negedge clk);
    check("c0_req", 64'(ibus_req_o), 64'(0));
    step();                          // cycle 1
    @(negedge clk);
    check("c1_req",  64'(ibus_req_o),  64'(1));
    check("c1_addr", 64'(ibus_addr_o), 64'(32'h0));
    step();                          // cycle 2
    @(negedge clk);
    check("c2_addr",  64'(ibus_addr_o),  64'(32'h4));
    check("c2_valid", 64'(inst_valid_o), 64'(0));
    step();                          // cycle 3
    @(negedge clk);
    check("c3_valid",     64'(inst_valid_o), 64'(1));
    check("c3_inst",      64'(inst_o),       64'(32'h0000_FFFF));
    check("c3_inst_addr", 64'(inst_addr_o),  64'(32'h0));
    repeat (12) step();

    // Downstream hold for 5 cycles: request stops once credit is used up.
    hold_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check("hold_req_off", 64'(ibus_req_o),   64'(0));
        check("hold_valid",   64'(inst_valid_o), 64'(1));
        check("hold_full",    64'(dbg_o.fifo_full), 64'(1));
      end
      step();
    end
    hold_en = 1'b0;
    repeat (8) step();

    // Jump with 2 outstanding (latency 2); the jump cycle coincides with the
    // first stale response.
    rst = 1'b0;
    step();
    lat_min = 2;
    lat_max = 2;
    rst = 1'b1;                      // cycle 0
    step();                          // cycle 1: grant 0x0
    step();                          // cycle 2: grant 0x4
    step();                          // cycle 3: J
    lat_min   = 1;
    lat_max   = 1;
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0100;
    @(negedge clk);
    check("j_out",     64'(dbg_o.outstanding), 64'(2));
    check("j_req_off", 64'(ibus_req_o),        64'(0));
    step();                          // J+1
    jump_en = 1'b0;
    @(negedge clk);
    check("j1_req",  64'(ibus_req_o),  64'(1));
    check("j1_addr", 64'(ibus_addr_o), 64'(32'h100));
    step();                          // J+2
    @(negedge clk);
    check("j2_valid",   64'(inst_valid_o),  64'(0));
    check("j2_discard", 64'(dbg_o.discard), 64'(0));
    step();                          // J+3
    @(negedge clk);
    check("j3_valid",     64'(inst_valid_o), 64'(1));
    check("j3_inst_addr", 64'(inst_addr_o),  64'(32'h100));
    check("j3_inst",      64'(inst_o),       64'(32'h0000_FEFF));
    repeat (6) step();

    // Jump coincident with rvalid, then a second jump the next cycle.
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ibus_rvalid_i) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("rvalid_seen_for_jump", 64'(found), 64'(1));
    jump_en   = 1'b1;
    jump_addr = 32'h0000_0200;       // J
    step();
    jump_addr = 32'h0000_0300;       // J+1, wins
    step();
    jump_en = 1'b0;                  // J+2: first request to 0x300
    step();                          // J+3
    @(negedge clk);
    check("jj_valid_early", 64'(inst_valid_o), 64'(0));
    step();                          // J+4
    @(negedge clk);
    check("jj_valid",     64'(inst_valid_o),  64'(1));
    check("jj_inst_addr", 64'(inst_addr_o),   64'(32'h300));
    check("jj_discard",   64'(dbg_o.discard), 64'(0));
    repeat (6) step();

    // Random grant stalls, latency 1..3, random hold and occasional jumps.
    gnt_rand = 1'b1;
    lat_min  = 1;
    lat_max  = 3;
    for (int i = 0; i < 250; i++) begin
      hold_en   = ($urandom_range(0, 3) == 0);
      jump_en   = ($urandom_range(0, 19) == 0);
      jump_addr = 32'h0000_1000 + (32'($urandom_range(0, 63)) << 2);
      step();
      checks++;
      if (exp_q.size() > DEPTH) begin
        errors++;
        $display("FAIL sb_backlog: got %0d pending, expected <= %0d", exp_q.size(), DEPTH);
      end
    end
    jump_en  = 1'b0;
    hold_en  = 1'b0;
    gnt_rand = 1'b0;
    repeat (8) step();
    check("rand_discard_zero", 64'(dbg_o.discard), 64'(0));

    // Reset mid-transaction with a full FIFO and requests in flight.
    lat_min = 3;
    lat_max = 3;
    hold_en = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("pre_rst_full", 64'(dbg_o.fifo_full), 64'(1));
    step();
    #1;
    rst = 1'b0;                      // asynchronous, between clock edges
    #1;
    check_reset_outputs("async_rst");
    hold_en = 1'b0;
    lat_min = 1;
    lat_max = 1;
    step();
    rst = 1'b1;                      // cycle 0
    step();                          // cycle 1
    @(negedge clk);
    check("restart_req",  64'(ibus_req_o),  64'(1));
    check("restart_addr", 64'(ibus_addr_o), 64'(RST_PC));
    repeat (12) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
